// File: rtl/beat_timing_gen.sv
// Machine-cycle timing generator: T1-T4 phase and W1-W3 beat strobes for the
// hardwired controller, with qd start sync, single-step and a beat counter.
module beat_timing_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             qd,
    input  logic             step,
    input  logic             short,
    input  logic             long,
    input  logic             stop,
    output logic             t1,
    output logic             t2,
    output logic             t3,
    output logic             t4,
    output logic             w1,
    output logic             w2,
    output logic             w3,
    output logic             running,
    output logic [CNT_W-1:0] beat_cnt
);
    typedef enum logic {S_HALT, S_RUN} state_t;
    typedef enum logic [1:0] {PH_T1, PH_T2, PH_T3, PH_T4} phase_t;
    typedef enum logic [1:0] {B_W1, B_W2, B_W3} beat_t;

    state_t           r_state;
    phase_t           r_phase;
    beat_t            r_beat;
    beat_t            r_nxt_beat;
    logic             r_q1;
    logic             r_q2;
    logic             r_q3;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_t;
    logic [2:0]       r_w;
    logic             r_running;

    state_t           w_state_n;
    phase_t           w_phase_n;
    beat_t            w_beat_n;
    beat_t            w_nxt_n;
    beat_t            w_follow;
    logic             w_cnt_inc;
    logic             w_qd_rise;
    logic [3:0]       w_t_n;
    logic [2:0]       w_w_n;

    assign w_qd_rise = r_q2 & ~r_q3;

    always_comb begin
        w_state_n = r_state;
        w_phase_n = r_phase;
        w_beat_n  = r_beat;
        w_nxt_n   = r_nxt_beat;
        w_cnt_inc = 1'b0;
        w_follow  = B_W1;
        w_t_n     = 4'b0000;
        w_w_n     = 3'b000;

        unique case (r_beat)
            B_W1:    w_follow = short ? B_W1 : B_W2;
            B_W2:    w_follow = long ? B_W3 : B_W1;
            default: w_follow = B_W1;
        endcase

        unique case (r_state)
            S_HALT: begin
                if (w_qd_rise) begin
                    w_state_n = S_RUN;
                    w_phase_n = PH_T1;
                    w_beat_n  = r_nxt_beat;
                end
            end
            default: begin
                if (r_phase != PH_T4) begin
                    w_phase_n = phase_t'(r_phase + 2'd1);
                end else begin
                    w_cnt_inc = 1'b1;
                    w_phase_n = PH_T1;
                    if (stop | step) begin
                        w_state_n = S_HALT;
                        w_nxt_n   = w_follow;
                    end else begin
                        w_beat_n  = w_follow;
                    end
                end
            end
        endcase

        // Strobes are registered from next-state so they toggle on clean edges
        if (w_state_n == S_RUN) begin
            w_t_n = 4'b0001 << w_phase_n;
            w_w_n = 3'b001 << w_beat_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_HALT;
            r_phase    <= PH_T1;
            r_beat     <= B_W1;
            r_nxt_beat <= B_W1;
            r_q1       <= 1'b0;
            r_q2       <= 1'b0;
            r_q3       <= 1'b0;
            r_cnt      <= '0;
            r_t        <= 4'b0000;
            r_w        <= 3'b000;
            r_running  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_phase    <= w_phase_n;
            r_beat     <= w_beat_n;
            r_nxt_beat <= w_nxt_n;
            r_q1       <= qd;
            r_q2       <= r_q1;
            r_q3       <= r_q2;
            if (w_cnt_inc) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            r_t        <= w_t_n;
            r_w        <= w_w_n;
            r_running  <= (w_state_n == S_RUN);
        end
    end

    assign {t4, t3, t2, t1} = r_t;
    assign {w3, w2, w1}     = r_w;
    assign running          = r_running;
    assign beat_cnt         = r_cnt;
endmodule

// File: tb/tb_beat_timing_gen.sv
// Bench for beat_timing_gen: cycle-level behavioural model compared every
// cycle, plus directed beat-sequence and latency expectations.
module tb_beat_timing_gen;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             qd = 1'b0;
    logic             step = 1'b0;
    logic             short = 1'b0;
    logic             long = 1'b0;
    logic             stop = 1'b0;
    logic             t1, t2, t3, t4, w1, w2, w3, running;
    logic [CNT_W-1:0] beat_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    int seen_b[$];
    int seen_c[$];

    beat_timing_gen #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .qd(qd), .step(step),
        .short(short), .long(long), .stop(stop),
        .t1(t1), .t2(t2), .t3(t3), .t4(t4),
        .w1(w1), .w2(w2), .w3(w3),
        .running(running), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    // Model: beat position 1..4, beat number 1..3, resume beat, sync history
    bit m_run = 0;
    int m_ph = 1;
    int m_beat = 1;
    int m_nxt = 1;
    int m_cnt = 0;
    bit m_s1 = 0, m_s2 = 0, m_s3 = 0;

    always @(posedge clk) begin
        bit rise;
        int nb;
        rise = m_s2 && !m_s3;
        if (rst) begin
            m_run = 0; m_ph = 1; m_beat = 1; m_nxt = 1; m_cnt = 0;
            m_s1 = 0; m_s2 = 0; m_s3 = 0;
        end else begin
            if (!m_run) begin
                if (rise) begin
                    m_run = 1; m_ph = 1; m_beat = m_nxt;
                end
            end else if (m_ph < 4) begin
                m_ph = m_ph + 1;
            end else begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                if (m_beat == 1) nb = short ? 1 : 2;
                else if (m_beat == 2) nb = long ? 3 : 1;
                else nb = 1;
                m_ph = 1;
                if (stop || step) begin
                    m_run = 0; m_nxt = nb;
                end else begin
                    m_beat = nb;
                end
            end
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = qd;
        end
    end

    function automatic logic [7:0] model_vec();
        logic [7:0] v;
        v = 8'd0;
        if (m_run) begin
            v[m_ph + 3] = 1'b1;
            v[m_beat]   = 1'b1;
            v[0]        = 1'b1;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if ({t4, t3, t2, t1, w3, w2, w1, running} !== model_vec()) begin
                n_fail++;
                $display("FAIL strobes t=%0t act=%b req=%b", $time,
                         {t4, t3, t2, t1, w3, w2, w1, running}, model_vec());
            end
            n_tests++;
            if (beat_cnt !== CNT_W'(m_cnt)) begin
                n_fail++;
                $display("FAIL beat_cnt t=%0t act=%0d req=%0d", $time, beat_cnt, m_cnt);
            end
        end
        if (t1) begin
            seen_b.push_back(w1 ? 1 : w2 ? 2 : w3 ? 3 : 0);
            seen_c.push_back(int'(beat_cnt));
        end
    end

    function automatic int dut_ph();
        return t1 ? 1 : t2 ? 2 : t3 ? 3 : t4 ? 4 : 0;
    endfunction

    function automatic int dut_b();
        return w1 ? 1 : w2 ? 2 : w3 ? 3 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s act=%0d req=%0d", name, act, req);
        end
    endtask

    task automatic chk_seq(input string name, input int req[$]);
        chk({name, "_len"}, seen_b.size(), req.size());
        for (int i = 0; i < req.size() && i < seen_b.size(); i++)
            chk($sformatf("%s_%0d", name, i), seen_b[i], req[i]);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; qd = 0; step = 0; short = 0; long = 0; stop = 0;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_qd();
        qd = 1'b1;
        tick();
        qd = 1'b0;
    endtask

    task automatic clear_seen();
        seen_b.delete();
        seen_c.delete();
    endtask

    task automatic wait_seen(input int n, input int budget);
        int k;
        k = 0;
        while (seen_b.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (seen_b.size() < n) begin
            n_tests++; n_fail++;
            $display("FAIL timeout_seen act=%0d req=%0d", seen_b.size(), n);
        end
    endtask

    task automatic wait_ph(input int ph, input int b);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(dut_ph() == ph && dut_b() == b) && k < 100);
        if (!(dut_ph() == ph && dut_b() == b)) begin
            n_tests++; n_fail++;
            $display("FAIL timeout_phase act=%0d/%0d req=%0d/%0d", dut_ph(), dut_b(), ph, b);
        end
    endtask

    task automatic wait_run(input bit lvl);
        int k;
        k = 0;
        while (running !== lvl && k < 50) begin
            tick();
            k++;
        end
        if (running !== lvl) begin
            n_tests++; n_fail++;
            $display("FAIL timeout_running act=%b req=%b", running, lvl);
        end
    endtask

    initial begin
        int lat;
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        tick();
        chk("reset_running", running, 0);
        chk("reset_cnt", beat_cnt, 0);
        chk("reset_strobes", {t4, t3, t2, t1, w3, w2, w1}, 0);

        // Start latency and free-run
        clear_seen();
        qd = 1'b1;
        lat = 0;
        while (!t1 && lat < 10) begin
            tick();
            lat++;
        end
        qd = 1'b0;
        chk("qd_latency", lat, 3);
        wait_seen(5, 40);
        chk_seq("freerun", '{1, 2, 1, 2, 1});
        for (int i = 0; i < 5 && i < seen_c.size(); i++)
            chk($sformatf("freerun_cnt_%0d", i), seen_c[i], i);

        // Short held, then released with long still high
        do_reset();
        clear_seen();
        short = 1; long = 1;
        pulse_qd();
        wait_seen(3, 30);
        short = 0;
        wait_seen(6, 30);
        long = 0;
        chk_seq("short", '{1, 1, 1, 2, 3, 1});

        // Long only during W2, then a long pulse confined to T2
        do_reset();
        clear_seen();
        pulse_qd();
        wait_ph(1, 2);
        long = 1;
        wait_ph(4, 2);
        tick();
        long = 0;
        wait_seen(4, 30);
        wait_ph(2, 2);
        long = 1;
        tick();
        long = 0;
        wait_seen(6, 30);
        chk_seq("long", '{1, 2, 3, 1, 2, 1});

        // Stop at T4 of first W1, then resume
        do_reset();
        pulse_qd();
        wait_ph(4, 1);
        stop = 1;
        tick();
        chk("stop_running", running, 0);
        chk("stop_strobes", {t4, t3, t2, t1, w3, w2, w1}, 0);
        chk("stop_cnt", beat_cnt, 1);
        stop = 0;
        repeat (3) tick();
        clear_seen();
        pulse_qd();
        wait_seen(1, 10);
        chk_seq("resume", '{2});

        // Single-step: four qd pulses, four beats
        do_reset();
        clear_seen();
        step = 1;
        for (int i = 0; i < 4; i++) begin
            pulse_qd();
            wait_run(1'b1);
            wait_run(1'b0);
            chk($sformatf("step_halt_%0d", i), running, 0);
        end
        step = 0;
        chk_seq("step", '{1, 2, 1, 2});
        chk("step_cnt", beat_cnt, 4);

        // Reset in T2 of W2, resume at W1, then wrap the counter
        do_reset();
        pulse_qd();
        wait_ph(2, 2);
        rst = 1;
        tick();
        rst = 0;
        chk("midrst_running", running, 0);
        chk("midrst_strobes", {t4, t3, t2, t1, w3, w2, w1}, 0);
        chk("midrst_cnt", beat_cnt, 0);
        clear_seen();
        pulse_qd();
        wait_seen(17, 100);
        if (seen_b.size() >= 17) begin
            chk("wrap_first_beat", seen_b[0], 1);
            chk("wrap_cnt_15", seen_c[15], 15);
            chk("wrap_cnt_16", seen_c[16], 0);
        end

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
